// File: rtl/counter_seek_ctrl_if.sv
// counter_seek_ctrl_if: request, counter-side and status signals of the seek controller
interface counter_seek_ctrl_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] Target;
    logic             Jump;
    logic             Target_Valid;
    logic             Target_Ready;
    logic [WIDTH-1:0] Counter;
    logic             High;
    logic             Low;
    logic [WIDTH-1:0] IN;
    logic             Load;
    logic             Up;
    logic             Down;
    logic             Busy;
    logic             Done;
    logic             Error;
    modport master (
        output Target, Jump, Target_Valid, Counter, High, Low,
        input  Target_Ready, IN, Load, Up, Down, Busy, Done, Error
    );
    modport slave (
        input  Target, Jump, Target_Valid, Counter, High, Low,
        output Target_Ready, IN, Load, Up, Down, Busy, Done, Error
    );
endinterface

// File: rtl/counter_seek_ctrl.sv
// counter_seek_ctrl: drives a saturating up/down counter to a requested value by load or paced steps
module counter_seek_ctrl #(
    parameter int WIDTH = 5,
    parameter int HOLD  = 0
) (
    input logic                clk,
    input logic                rst,
    counter_seek_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, EVAL, PULSE_UP, PULSE_DN, SETTLE, DONE, ERROR} state_t;
    localparam logic [WIDTH:0] STEP_MAX  = {1'b1, {WIDTH{1'b0}}};
    localparam logic [7:0]     HOLD_LAST = 8'(HOLD - 1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH:0]   step_q, step_d;
    logic [7:0]       hold_q, hold_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            step_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
        end
    end
    // step_q bounds the number of pulses so a disturbed counter cannot trap us in EVAL forever
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:               state_d = bus.Target_Valid ? (bus.Jump ? LOAD : EVAL) : IDLE;
            LOAD:               state_d = EVAL;
            EVAL:               state_d = bus.Counter == tgt_q ? DONE
                                        : step_q == STEP_MAX ? ERROR
                                        : bus.Counter < tgt_q ? (bus.High ? ERROR : PULSE_UP)
                                        : (bus.Low ? ERROR : PULSE_DN);
            PULSE_UP, PULSE_DN: state_d = HOLD > 0 ? SETTLE : EVAL;
            SETTLE:             state_d = hold_q == HOLD_LAST ? EVAL : SETTLE;
            default:            state_d = IDLE;
        endcase
        tgt_d  = state_q == IDLE && bus.Target_Valid ? bus.Target : tgt_q;
        step_d = state_q == IDLE ? '0
               : step_q + {{WIDTH{1'b0}}, state_q == PULSE_UP || state_q == PULSE_DN};
        hold_d = state_q == SETTLE ? hold_q + 8'd1 : 8'd0;
    end
    always_comb begin
        bus.Target_Ready = state_q == IDLE;
        bus.Busy         = state_q != IDLE;
        bus.IN           = state_q == IDLE ? '0 : tgt_q;
        bus.Load         = state_q == LOAD;
        bus.Up           = state_q == PULSE_UP;
        bus.Down         = state_q == PULSE_DN;
        bus.Done         = state_q == DONE;
        bus.Error        = state_q == ERROR;
    end
endmodule

// File: tb/tb_counter_seek_ctrl.sv
// tb_counter_seek_ctrl: directed and randomized requests on HOLD=0 and HOLD=2 controllers,
// each closing the loop through a behavioural saturating counter with fault injection
module tb_counter_seek_ctrl;
    localparam int W = 5;
    localparam logic [11:0] IDLE_V = {1'b1, 11'b0};
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;
    logic [W-1:0] tgt_r [2];
    logic         jmp_r [2];
    logic         vld_r [2];
    logic [W-1:0] cnt [2] = '{5'd0, 5'd0};
    logic         pre_en [2] = '{1'b0, 1'b0};
    logic [W-1:0] pre_v [2];
    logic         ign_load [2] = '{1'b0, 1'b0};
    logic         ign_up [2] = '{1'b0, 1'b0};
    logic         frc_hi [2] = '{1'b0, 1'b0};
    logic         frc_lo [2] = '{1'b0, 1'b0};
    logic [11:0]  obs [2];

    for (genvar g = 0; g < 2; g++) begin : gen_d
        counter_seek_ctrl_if #(.WIDTH(W)) bus ();
        counter_seek_ctrl #(.WIDTH(W), .HOLD(2 * g)) dut (.clk(clk), .rst(rst), .bus(bus));
        assign bus.Target       = tgt_r[g];
        assign bus.Jump         = jmp_r[g];
        assign bus.Target_Valid = vld_r[g];
        assign bus.Counter      = cnt[g];
        assign bus.High         = frc_hi[g] || cnt[g] == 5'd31;
        assign bus.Low          = frc_lo[g] || cnt[g] == 5'd0;
        assign obs[g] = {bus.Target_Ready, bus.Busy, bus.Load, bus.Up, bus.Down,
                         bus.Done, bus.Error, bus.IN};
        always @(posedge clk)
            if (pre_en[g]) cnt[g] <= pre_v[g];
            else if (bus.Load && !ign_load[g]) cnt[g] <= bus.IN;
            else if (bus.Up && !ign_up[g] && cnt[g] != 5'd31) cnt[g] <= cnt[g] + 5'd1;
            else if (bus.Down && cnt[g] != 5'd0) cnt[g] <= cnt[g] - 5'd1;
    end

    // Expected outputs in cycle k of a request accepted in cycle 0: pulses every p cycles after
    // the first evaluation cycle, then one Done/Error cycle
    function automatic logic [11:0] expv(int k, int t, int base, int n, int p, bit up, bit j, bit err, int endc);
        bit pulse;
        if (k == 0) return IDLE_V;
        pulse = k > base && (k - base - 1) % p == 0 && (k - base - 1) / p < n;
        return {1'b0, 1'b1, j && k == 1, pulse && up, pulse && !up,
                k == endc && !err, k == endc && err, 5'(t)};
    endfunction

    task automatic run(input int d, input int c, input int t, input bit j, input bit hold_vld,
                       input string name, input int rst_at);
        int start, eff, base, n, p, endc;
        bit up, err;
        logic [11:0] e;
        start = c < 0 ? int'(cnt[d]) : c;
        eff   = j && !ign_load[d] ? t : start;
        base  = j ? 2 : 1;
        p     = 2 + 2 * d;
        up    = t > eff;
        if (eff == t) begin n = 0; err = 0; end
        else if (up ? frc_hi[d] : frc_lo[d]) begin n = 0; err = 1; end
        else if (up && ign_up[d]) begin n = 32; err = 1; end
        else begin n = up ? t - eff : eff - t; err = 0; end
        endc = base + n * p + 1;
        for (int k = 0; k <= endc; k++) begin
            @(negedge clk);
            e = expv(k, t, base, n, p, up, j, err, endc);
            checks++;
            if (obs[d] !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got {rdy,busy,ld,up,dn,done,err,in}=%b expected %b",
                         name, k, obs[d], e);
            end
            if (k == 0) begin
                tgt_r[d] = 5'(t);
                jmp_r[d] = j;
                vld_r[d] = 1'b1;
                pre_en[d] = c >= 0;
                pre_v[d] = 5'(start);
            end else begin
                pre_en[d] = 1'b0;
                vld_r[d] = hold_vld && k < endc;
                if (hold_vld) begin
                    tgt_r[d] = 5'($urandom);
                    jmp_r[d] = 1'($urandom);
                end
            end
            if (k == rst_at) begin
                rst = 1'b1;
                break;
            end
        end
        if (rst_at < 0) begin
            checks++;
            if (int'(cnt[d]) != (err ? eff : t)) begin
                errors++;
                $display("FAIL %s final counter: got %0d expected %0d", name, cnt[d], err ? eff : t);
            end
        end
    endtask

    task automatic test_reset();
        vld_r = '{1'b0, 1'b0};
        tgt_r = '{5'd0, 5'd0};
        jmp_r = '{1'b0, 1'b0};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== IDLE_V) begin
                errors++;
                $display("FAIL reset dut%0d: got %b expected %b", d, obs[d], IDLE_V);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        run(0, 3, 7, 0, 0, "ramp_up", -1);
        run(0, 9, 30, 0, 0, "ramp_long", -1);
    endtask

    task automatic test_jump();
        run(0, 3, 25, 1, 0, "jump", -1);
        run(1, 31, 0, 1, 0, "jump_hold", -1);
    endtask

    task automatic test_hold_down();
        run(1, 2, 0, 0, 0, "hold_down", -1);
        run(1, 28, 31, 0, 0, "hold_up_to_max", -1);
    endtask

    task automatic test_null();
        run(0, 12, 12, 0, 1, "null", -1);
        run(1, 0, 0, 1, 1, "null_jump_hold", -1);
    endtask

    task automatic test_saturation();
        frc_hi[0] = 1'b1;
        run(0, 28, 31, 0, 0, "sat_high", -1);
        frc_hi[0] = 1'b0;
        frc_lo[0] = 1'b1;
        ign_load[0] = 1'b1;
        run(0, 31, 30, 1, 0, "sat_low_after_load", -1);
        frc_lo[0] = 1'b0;
        ign_load[0] = 1'b0;
        ign_up[0] = 1'b1;
        run(0, 5, 20, 0, 0, "step_guard", -1);
        ign_up[0] = 1'b0;
    endtask

    task automatic test_jump_fallback();
        ign_load[0] = 1'b1;
        run(0, 10, 14, 1, 0, "jump_fallback", -1);
        ign_load[0] = 1'b0;
        ign_load[1] = 1'b1;
        run(1, 20, 17, 1, 0, "jump_fallback_hold", -1);
        ign_load[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        run(0, 3, 7, 0, 0, "mid_rst", 2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (obs[0] !== IDLE_V) begin
                errors++;
                $display("FAIL mid_rst after %0d: got %b expected %b", k, obs[0], IDLE_V);
            end
            rst = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int d, t;
        bit j;
        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(1, 0));
            t = int'($urandom_range(31, 0));
            j = 1'($urandom);
            ign_load[d] = j && $urandom_range(3, 0) == 0;
            run(d, i % 3 == 0 ? int'($urandom_range(31, 0)) : -1, t, j, 1'($urandom), "rand", -1);
            ign_load[d] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_jump();
        test_hold_down();
        test_null();
        test_saturation();
        test_jump_fallback();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
